// File: rtl/seg_pkg.sv
// Shared types and constants for the multiplexed 8-segment display controller.
package seg_pkg;

    localparam int unsigned NUM_DIGITS_DEF = 4;
    localparam int unsigned SEG_W          = 8;
    localparam int unsigned WR_ADDR_W      = 2;

    typedef enum logic {
        PhBlank,
        PhDrive
    } phase_e;

    // Segment a = bit 0 ... g = bit 6, dp = bit 7.
    localparam logic [SEG_W-1:0] GLYPH_0 = 8'h3F;
    localparam logic [SEG_W-1:0] GLYPH_1 = 8'h06;
    localparam logic [SEG_W-1:0] GLYPH_2 = 8'h5B;
    localparam logic [SEG_W-1:0] GLYPH_3 = 8'h4F;
    localparam logic [SEG_W-1:0] GLYPH_4 = 8'h66;
    localparam logic [SEG_W-1:0] GLYPH_5 = 8'h6D;
    localparam logic [SEG_W-1:0] GLYPH_6 = 8'h7D;
    localparam logic [SEG_W-1:0] GLYPH_7 = 8'h07;
    localparam logic [SEG_W-1:0] GLYPH_8 = 8'h7F;
    localparam logic [SEG_W-1:0] GLYPH_9 = 8'h6F;
    localparam logic [SEG_W-1:0] GLYPH_A = 8'h77;
    localparam logic [SEG_W-1:0] GLYPH_B = 8'h7C;
    localparam logic [SEG_W-1:0] GLYPH_C = 8'h39;
    localparam logic [SEG_W-1:0] GLYPH_D = 8'h5E;
    localparam logic [SEG_W-1:0] GLYPH_E = 8'h79;
    localparam logic [SEG_W-1:0] GLYPH_F = 8'h71;

    function automatic logic [SEG_W-1:0] hex_glyph(input logic [3:0] nibble);
        logic [SEG_W-1:0] g;
        unique case (nibble)
            4'h0: g = GLYPH_0;
            4'h1: g = GLYPH_1;
            4'h2: g = GLYPH_2;
            4'h3: g = GLYPH_3;
            4'h4: g = GLYPH_4;
            4'h5: g = GLYPH_5;
            4'h6: g = GLYPH_6;
            4'h7: g = GLYPH_7;
            4'h8: g = GLYPH_8;
            4'h9: g = GLYPH_9;
            4'hA: g = GLYPH_A;
            4'hB: g = GLYPH_B;
            4'hC: g = GLYPH_C;
            4'hD: g = GLYPH_D;
            4'hE: g = GLYPH_E;
            default: g = GLYPH_F;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/seg_dbuf.sv
// Shadow/active segment banks with write handshake and frame-aligned commit.
module seg_dbuf
    import seg_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = NUM_DIGITS_DEF,
    parameter int unsigned DIG_W      = 2
) (
    input  logic                 i_CLK,
    input  logic                 i_RST_N,
    input  logic                 i_wr_valid,
    output logic                 o_wr_ready,
    input  logic [WR_ADDR_W-1:0] i_wr_addr,
    input  logic [SEG_W-1:0]     i_wr_data,
    input  logic                 i_commit,
    input  logic                 i_boundary,
    input  logic [DIG_W-1:0]     i_rd_idx,
    output logic [SEG_W-1:0]     o_rd_data,
    output logic                 o_commit_done
);

    logic [SEG_W-1:0] shadow_q [NUM_DIGITS];
    logic [SEG_W-1:0] shadow_d [NUM_DIGITS];
    logic [SEG_W-1:0] active_q [NUM_DIGITS];
    logic [SEG_W-1:0] active_d [NUM_DIGITS];
    logic             pending_q, pending_d;
    logic             commit_done_q;
    logic             wr_fire;

    assign o_wr_ready    = !pending_q;
    assign o_commit_done = commit_done_q;

    always_comb begin
        shadow_d  = shadow_q;
        active_d  = active_q;
        pending_d = pending_q;
        wr_fire   = i_wr_valid && !pending_q;

        // Addresses beyond the last digit match no entry and are dropped.
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (wr_fire && (32'(i_wr_addr) == 32'(i))) begin
                shadow_d[i] = i_wr_data;
            end
        end

        // A commit arriving while one is already pending is absorbed.
        if (pending_q) begin
            if (i_boundary) begin
                active_d  = shadow_q;
                pending_d = 1'b0;
            end
        end else if (i_commit) begin
            pending_d = 1'b1;
        end
    end

    always_comb begin
        o_rd_data = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (32'(i_rd_idx) == 32'(i)) begin
                o_rd_data = active_q[i];
            end
        end
    end

    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            shadow_q      <= '{default: '0};
            active_q      <= '{default: '0};
            pending_q     <= 1'b0;
            commit_done_q <= 1'b0;
        end else begin
            shadow_q      <= shadow_d;
            active_q      <= active_d;
            pending_q     <= pending_d;
            commit_done_q <= i_boundary && pending_q;
        end
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Digit scan controller: slot/digit counters, blank/drive phase FSM, PWM and
// registered drain/segment outputs fed from a double-buffered frame.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = NUM_DIGITS_DEF,
    parameter int unsigned PRESCALE   = 4096,
    parameter int unsigned BLANK      = 64,
    parameter int unsigned PWM_BITS   = 4
) (
    input  logic                  i_CLK,
    input  logic                  i_RST_N,
    input  logic                  i_wr_valid,
    output logic                  o_wr_ready,
    input  logic [WR_ADDR_W-1:0]  i_wr_addr,
    input  logic [SEG_W-1:0]      i_wr_data,
    input  logic                  i_commit,
    output logic                  o_commit_done,
    input  logic [PWM_BITS-1:0]   i_brightness,
    input  logic                  i_oe,
    output logic                  o_frame_start,
    output logic [NUM_DIGITS-1:0] o_drains,
    output logic [SEG_W-1:0]      o_leds
);

    localparam int unsigned CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int unsigned DIG_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(PRESCALE - 1);
    localparam logic [DIG_W-1:0] DIGIT_LAST = DIG_W'(NUM_DIGITS - 1);

    logic [CNT_W-1:0]      slot_cnt_q, slot_cnt_d;
    logic [DIG_W-1:0]      digit_q, digit_d;
    phase_e                phase_q, phase_d;
    logic [PWM_BITS-1:0]   bright_q, bright_d;
    logic                  frame_start_q;
    logic [NUM_DIGITS-1:0] drains_q, drains_d;
    logic [SEG_W-1:0]      leds_q, leds_d;
    logic                  slot_wrap;
    logic                  frame_boundary;
    logic [PWM_BITS-1:0]   pwm;
    logic [SEG_W-1:0]      cur_seg;

    seg_dbuf #(
        .NUM_DIGITS (NUM_DIGITS),
        .DIG_W      (DIG_W)
    ) u_dbuf (
        .i_CLK         (i_CLK),
        .i_RST_N       (i_RST_N),
        .i_wr_valid    (i_wr_valid),
        .o_wr_ready    (o_wr_ready),
        .i_wr_addr     (i_wr_addr),
        .i_wr_data     (i_wr_data),
        .i_commit      (i_commit),
        .i_boundary    (frame_boundary),
        .i_rd_idx      (digit_q),
        .o_rd_data     (cur_seg),
        .o_commit_done (o_commit_done)
    );

    // Counters and phase next-state.
    always_comb begin
        slot_cnt_d     = slot_cnt_q + CNT_W'(1);
        digit_d        = digit_q;
        slot_wrap      = (slot_cnt_q == SLOT_LAST);
        frame_boundary = slot_wrap && (digit_q == DIGIT_LAST);
        bright_d       = bright_q;

        if (slot_wrap) begin
            slot_cnt_d = '0;
            digit_d    = (digit_q == DIGIT_LAST) ? '0 : digit_q + DIG_W'(1);
        end
        if (frame_boundary) begin
            bright_d = i_brightness;
        end

        phase_d = (32'(slot_cnt_d) < BLANK) ? PhBlank : PhDrive;
    end

    // Pin values for the current slot; registered below.
    always_comb begin
        pwm      = slot_cnt_q[PWM_BITS-1:0];
        drains_d = '0;
        leds_d   = '0;
        if (i_oe && (phase_q == PhDrive)) begin
            leds_d = cur_seg;
            if (pwm < bright_q) begin
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    drains_d[i] = (32'(digit_q) == 32'(i));
                end
            end
        end
    end

    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            slot_cnt_q    <= '0;
            digit_q       <= '0;
            phase_q       <= PhBlank;
            bright_q      <= '0;
            frame_start_q <= 1'b0;
            drains_q      <= '0;
            leds_q        <= '0;
        end else begin
            slot_cnt_q    <= slot_cnt_d;
            digit_q       <= digit_d;
            phase_q       <= phase_d;
            bright_q      <= bright_d;
            frame_start_q <= frame_boundary;
            drains_q      <= drains_d;
            leds_q        <= leds_d;
        end
    end

    assign o_frame_start = frame_start_q;
    assign o_drains      = drains_q;
    assign o_leds        = leds_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Randomized self-checking bench for seg_scan_ctrl against a cycle-count model.
module tb_seg_scan_ctrl;

    localparam int ND = 4;
    localparam int PS = 32;
    localparam int BL = 4;
    localparam int PB = 4;
    localparam int FRAME = ND * PS;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_valid = 1'b0;
    logic       wr_ready;
    logic [1:0] wr_addr = '0;
    logic [7:0] wr_data = '0;
    logic       commit = 1'b0;
    logic       commit_done;
    logic [3:0] brightness = 4'd15;
    logic       oe = 1'b1;
    logic       frame_start;
    logic [3:0] drains;
    logic [7:0] leds;

    int checks = 0;
    int failures = 0;

    // Model state: edges since reset release, banks, pending flag, latched brightness.
    int         n;
    logic [7:0] m_shadow [ND];
    logic [7:0] m_active [ND];
    bit         m_pending;
    int         m_bright;
    logic [3:0] exp_drains;
    logic [7:0] exp_leds;
    bit         exp_fs, exp_cd, exp_ready;
    int         cd_seen;

    seg_scan_ctrl #(
        .NUM_DIGITS (ND),
        .PRESCALE   (PS),
        .BLANK      (BL),
        .PWM_BITS   (PB)
    ) dut (
        .i_CLK         (clk),
        .i_RST_N       (rst_n),
        .i_wr_valid    (wr_valid),
        .o_wr_ready    (wr_ready),
        .i_wr_addr     (wr_addr),
        .i_wr_data     (wr_data),
        .i_commit      (commit),
        .o_commit_done (commit_done),
        .i_brightness  (brightness),
        .i_oe          (oe),
        .o_frame_start (frame_start),
        .o_drains      (drains),
        .o_leds        (leds)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t n=%0d)", tag, got, exp, $time, n);
        end
    endtask

    task automatic model_reset();
        n         = 0;
        m_pending = 1'b0;
        m_bright  = 0;
        for (int i = 0; i < ND; i++) begin
            m_shadow[i] = '0;
            m_active[i] = '0;
        end
    endtask

    // Pins after an edge reflect the slot that was current before it.
    task automatic model_edge();
        int  slot;
        int  dig;
        bit  drive;
        bit  boundary;
        slot     = n % PS;
        dig      = (n / PS) % ND;
        drive    = slot >= BL;
        boundary = (slot == PS - 1) && (dig == ND - 1);

        exp_leds   = (oe && drive) ? m_active[dig] : 8'h00;
        exp_drains = (oe && drive && ((slot % (1 << PB)) < m_bright)) ? 4'(1 << dig) : 4'h0;
        exp_fs     = boundary;
        exp_cd     = boundary && m_pending;

        if (wr_valid && !m_pending && int'(wr_addr) < ND) m_shadow[wr_addr] = wr_data;
        if (m_pending) begin
            if (boundary) begin
                m_active  = m_shadow;
                m_pending = 1'b0;
            end
        end else if (commit) begin
            m_pending = 1'b1;
        end
        if (boundary) m_bright = int'(brightness);
        exp_ready = !m_pending;
        n++;
    endtask

    task automatic check_pins();
        check_eq("drains", 32'(drains), 32'(exp_drains));
        check_eq("leds", 32'(leds), 32'(exp_leds));
        check_eq("frame_start", 32'(frame_start), 32'(exp_fs));
        check_eq("commit_done", 32'(commit_done), 32'(exp_cd));
        check_eq("wr_ready", 32'(wr_ready), 32'(exp_ready));
        check_eq("drains_onehot", 32'($countones(drains) <= 1), 32'd1);
        if (commit_done) cd_seen++;
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        check_pins();
    endtask

    task automatic idle_inputs();
        wr_valid = 1'b0;
        commit   = 1'b0;
    endtask

    task automatic run(input int cycles);
        for (int i = 0; i < cycles; i++) cycle();
    endtask

    task automatic run_to_frame_pos(input int pos);
        run(((pos - (n % FRAME)) + FRAME) % FRAME);
    endtask

    task automatic check_reset_pins(input string tag);
        check_eq({tag, "_drains"}, 32'(drains), 32'd0);
        check_eq({tag, "_leds"}, 32'(leds), 32'd0);
        check_eq({tag, "_ready"}, 32'(wr_ready), 32'd1);
        check_eq({tag, "_cdone"}, 32'(commit_done), 32'd0);
        check_eq({tag, "_fstart"}, 32'(frame_start), 32'd0);
    endtask

    task automatic write(input logic [1:0] a, input logic [7:0] d, input bit c);
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_data  = d;
        commit   = c;
        cycle();
        idle_inputs();
    endtask

    initial begin
        int cd_base;
        logic [7:0] frame_bytes [4];
        frame_bytes = '{8'h3F, 8'h06, 8'h5B, 8'h4F};
        cd_seen = 0;
        model_reset();

        // Reset state and first frames.
        repeat (3) @(posedge clk);
        #1;
        check_reset_pins("reset");
        @(negedge clk);
        rst_n = 1'b1;
        run(2 * FRAME + 20);

        // Full frame write then commit; wr_ready low until the boundary.
        for (int i = 0; i < 4; i++) write(2'(i), frame_bytes[i], 1'b0);
        cd_base = cd_seen;
        commit = 1'b1;
        cycle();
        idle_inputs();
        run(2 * FRAME);
        check_eq("commit_once", 32'(cd_seen - cd_base), 32'd1);

        // Same-cycle write+commit, second commit absorbed while pending.
        cd_base = cd_seen;
        write(2'd2, 8'hA5, 1'b1);
        commit = 1'b1;
        cycle();
        wr_valid = 1'b1;
        wr_addr  = 2'd1;
        wr_data  = 8'hEE;
        cycle();
        idle_inputs();
        run(2 * FRAME);
        check_eq("absorb_commit", 32'(cd_seen - cd_base), 32'd1);

        // Brightness changed mid-frame, then fully dark.
        run_to_frame_pos(40);
        brightness = 4'd4;
        run(2 * FRAME);
        brightness = 4'd0;
        run(2 * FRAME);
        brightness = 4'd15;
        run(FRAME);

        // Output enable dropped mid-digit 2.
        run_to_frame_pos(2 * PS + 10);
        oe = 1'b0;
        run(50);
        oe = 1'b1;
        run(FRAME + 30);

        // Random traffic.
        for (int i = 0; i < 1500; i++) begin
            wr_valid = ($urandom % 2) == 0;
            wr_addr  = 2'($urandom % 4);
            wr_data  = 8'($urandom);
            commit   = ($urandom % 40) == 0;
            if (($urandom % 200) == 0) brightness = 4'($urandom);
            oe = ($urandom % 30) != 0;
            cycle();
        end
        idle_inputs();
        oe = 1'b1;
        brightness = 4'd15;
        run(2 * FRAME);

        // Async reset during drive with a commit pending.
        run_to_frame_pos(5);
        write(2'd0, 8'h77, 1'b1);
        run(12);
        check_eq("pre_rst_pending", 32'(wr_ready), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_pins("async_rst");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        cd_base = cd_seen;
        run(3 * FRAME);
        check_eq("no_commit_after_rst", 32'(cd_seen - cd_base), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
Scan and refresh controller for the 4-digit 8-segment LED display. It holds a double-buffered frame of per-digit segment bytes and time-multiplexes the digit drains, with dead-time blanking between digits and per-frame PWM brightness. A requester writes the shadow bank over a valid/ready port and requests a commit; the commit is applied atomically at the next frame boundary. It sits between the data sources (LFSR, CPU) and the drains/leds pins.

Parameters:
NUM_DIGITS, 4, number of multiplexed digits (drain lines)
PRESCALE, 4096, clocks per digit slot (must satisfy PRESCALE > BLANK and PRESCALE >= 2**PWM_BITS)
BLANK, 64, dead-time clocks at the start of each slot with all drains off
PWM_BITS, 4, brightness resolution

Ports:
i_CLK  in  1  system clock
i_RST_N  in  1  asynchronous reset, active-low
i_wr_valid  in  1  shadow write request
o_wr_ready  out  1  shadow write accept
i_wr_addr  in  2  digit index, 0 = drains[0]
i_wr_data  in  8  segment byte, bit = 1 lights the segment
i_commit  in  1  single-cycle pulse: copy shadow to active at next frame boundary
o_commit_done  out  1  single-cycle pulse when the copy occurs
i_brightness  in  PWM_BITS  duty value, sampled at frame start
i_oe  in  1  output enable
o_frame_start  out  1  single-cycle pulse at digit 0, slot_cnt 0
o_drains  out  NUM_DIGITS  one-hot digit enable, active-high
o_leds  out  8  segment outputs, active-high

Behaviour:
- Reset (async assert, sync release): slot_cnt = 0, digit = 0, phase = BLANK. Shadow and active banks = 0, bright_q = 0, pending = 0. o_drains = 0, o_leds = 0, o_wr_ready = 1, o_commit_done = 0, o_frame_start = 0.
- slot_cnt counts 0..PRESCALE-1.
  - At PRESCALE-1 it wraps to 0 and digit advances; digit wraps NUM_DIGITS-1 to 0.
  - A frame is NUM_DIGITS*PRESCALE clocks.
- Phases (FSM):
  - BLANK while slot_cnt < BLANK, then DRIVE for the rest of the slot.
  - BLANK: o_drains = 0, o_leds = 0.
  - DRIVE: o_leds = active[digit]. o_drains = one-hot(digit) only when pwm < bright_q, where pwm = slot_cnt[PWM_BITS-1:0]; otherwise 0.
  - bright_q = 0 keeps the display dark. Maximum value gives (2**PWM_BITS-1)/2**PWM_BITS duty.
- All outputs are registered: 1-clock latency from the counter/state to the pins.
- Frame boundary is the cycle where slot_cnt wraps and digit goes NUM_DIGITS-1 to 0. On that cycle:
  - bright_q <= i_brightness.
  - If pending: active <= shadow, pending <= 0, and o_commit_done pulses on the next cycle.
  - o_frame_start pulses in the first cycle of digit 0 (registered, aligned with o_commit_done).
- Write port:
  - A write is accepted when i_wr_valid & o_wr_ready: shadow[i_wr_addr] <= i_wr_data.
  - i_wr_addr >= NUM_DIGITS is accepted and discarded.
  - o_wr_ready = !pending, so the shadow is frozen between commit request and the copy.
- Commit:
  - i_commit sets pending.
  - A write and a commit in the same cycle: the write is accepted and included in the commit.
  - i_commit while pending is already set is absorbed (no second copy).
  - i_commit on the frame-boundary cycle itself takes effect at the following boundary.
- i_oe = 0 forces o_drains = 0 and o_leds = 0 from the next cycle. Counters, the commit logic and o_frame_start continue; the display resumes mid-frame when i_oe returns to 1.
- Reset mid-frame: the display blanks immediately, and any pending commit and shadow contents are lost.
- At no cycle is more than one o_drains bit high.

Decomposition:
- Package seg_pkg holds:
  - NUM_DIGITS default
  - the segment byte width (8)
  - the phase enum {BLANK, DRIVE}
  - the 7-segment hex glyph constants for sources to use.
- One sub-module, seg_dbuf: shadow/active register banks, the pending flag, write/commit handshake and o_commit_done.
- seg_scan_ctrl keeps the counters, FSM, PWM compare and output registers.

Test Plan:
All scenarios use NUM_DIGITS=4, PRESCALE=32, BLANK=4, PWM_BITS=4, i_brightness=15, i_oe=1 unless noted.
1. Reset release -> o_drains=0 and o_leds=0 for the first 5 clocks. o_frame_start pulses every 128 clocks. Digits scan 0,1,2,3 with drains 0001, 0010, 0100, 1000.
2. Write 0x3F,0x06,0x5B,0x4F to addr 0..3, then i_commit -> o_wr_ready low until the boundary. o_commit_done coincides with o_frame_start. In DRIVE, digit n shows its byte; o_leds = 0 throughout every BLANK phase.
3. Write plus i_commit in the same cycle, then a second i_commit while pending -> exactly one o_commit_done, and the active bank contains the same-cycle write.
4. i_brightness=4 set mid-frame -> no change until the next o_frame_start. Afterwards, within DRIVE, a drain is high only for pwm 0..3 of each 16-clock window. i_brightness=0 -> o_drains stays 0.
5. Drop i_oe for 50 clocks mid-digit 2 -> outputs 0 from the next clock. o_frame_start timing is unchanged, and drive resumes at the correct digit.
6. Assert i_RST_N=0 asynchronously during DRIVE with pending=1 -> outputs go 0 without a clock edge. After release: no o_commit_done, and active = all zeros.
